// File: rtl/decode_pkg.sv
// Shared constants and types for the registered decode stage: prefix bytes, segment
// encodings, fault-cause bit positions and the AGEN result bundle.
package decode_pkg;

  localparam logic [7:0] PfxRepne  = 8'hF2;
  localparam logic [7:0] PfxOpsize = 8'h66;
  localparam logic [7:0] PfxEs     = 8'h26;
  localparam logic [7:0] PfxCs     = 8'h2E;
  localparam logic [7:0] PfxSs     = 8'h36;
  localparam logic [7:0] PfxDs     = 8'h3E;
  localparam logic [7:0] PfxFs     = 8'h64;
  localparam logic [7:0] PfxGs     = 8'h65;

  localparam logic [2:0] SegEs = 3'd0;
  localparam logic [2:0] SegCs = 3'd1;
  localparam logic [2:0] SegSs = 3'd2;
  localparam logic [2:0] SegDs = 3'd3;
  localparam logic [2:0] SegFs = 3'd4;
  localparam logic [2:0] SegGs = 3'd5;

  localparam int unsigned FaultCauseW   = 3;
  localparam int unsigned FaultOverflow = 0;
  localparam int unsigned FaultLenZero  = 1;
  localparam int unsigned FaultLenMax   = 2;

  typedef struct packed {
    logic        fault;
    logic [7:0]  opcode;
    logic [7:0]  modrm;
    logic [7:0]  sib;
    logic [31:0] rel;
    logic [15:0] ptr_cs;
    logic [31:0] ptr_eip;
    logic [3:0]  pr_cnt;
    logic        repne;
    logic        opsize;
    logic        seg_v;
    logic [2:0]  seg;
    logic [31:0] next_eip;
  } agen_res_t;

  function automatic logic is_seg_prefix(input logic [7:0] b);
    case (b)
      PfxEs, PfxCs, PfxSs, PfxDs, PfxFs, PfxGs: is_seg_prefix = 1'b1;
      default:                                  is_seg_prefix = 1'b0;
    endcase
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    is_prefix = is_seg_prefix(b) || (b == PfxRepne) || (b == PfxOpsize);
  endfunction

  function automatic logic [2:0] seg_code(input logic [7:0] b);
    case (b)
      PfxEs:   seg_code = SegEs;
      PfxCs:   seg_code = SegCs;
      PfxSs:   seg_code = SegSs;
      PfxDs:   seg_code = SegDs;
      PfxFs:   seg_code = SegFs;
      PfxGs:   seg_code = SegGs;
      default: seg_code = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/decode_prefix_scan.sv
// Combinational legacy-prefix scanner: counts leading prefix bytes (capped at MAX_PREFIX)
// and summarises REPNE / operand-size / segment-override state.
module decode_prefix_scan #(
  parameter int unsigned MAX_PREFIX   = 4,
  parameter int unsigned WINDOW_BYTES = 16
) (
  input  logic [8*WINDOW_BYTES-1:0] i_window,
  output logic [3:0]                o_pr_cnt,
  output logic                      o_repne,
  output logic                      o_opsize,
  output logic                      o_seg_v,
  output logic [2:0]                o_seg,
  output logic                      o_overflow
);
  import decode_pkg::*;

  logic       w_run;
  logic [7:0] w_byte;

  always_comb begin
    w_run      = 1'b1;
    w_byte     = '0;
    o_pr_cnt   = '0;
    o_repne    = 1'b0;
    o_opsize   = 1'b0;
    o_seg_v    = 1'b0;
    o_seg      = '0;
    for (int i = 0; i < int'(MAX_PREFIX); i++) begin
      w_byte = i_window[8*i +: 8];
      if (w_run && is_prefix(w_byte)) begin
        o_pr_cnt = o_pr_cnt + 4'd1;
        if (w_byte == PfxRepne)  o_repne  = 1'b1;
        if (w_byte == PfxOpsize) o_opsize = 1'b1;
        // Later segment prefixes overwrite earlier ones.
        if (is_seg_prefix(w_byte)) begin
          o_seg_v = 1'b1;
          o_seg   = seg_code(w_byte);
        end
      end else begin
        w_run = 1'b0;
      end
    end
    o_overflow = w_run && is_prefix(i_window[8*MAX_PREFIX +: 8]);
  end

endmodule

// File: rtl/decode_pipe_stage.sv
// Registered decode stage: prefix scan, field extraction at the post-prefix offset,
// next-EIP and fault generation, and a stall-aware output register feeding AGEN.
module decode_pipe_stage #(
  parameter int unsigned MAX_PREFIX   = 4,
  parameter int unsigned WINDOW_BYTES = 16,
  parameter int unsigned MAX_INST_LEN = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      de_v,
  output logic                      de_ready,
  input  logic [8*WINDOW_BYTES-1:0] de_window,
  input  logic [31:0]               de_eip,
  input  logic [3:0]                de_body_len,
  input  logic                      flush,
  input  logic                      agen_stall,
  output logic                      agen_v,
  output logic                      agen_fault,
  output logic [7:0]                agen_opcode,
  output logic [7:0]                agen_modrm,
  output logic [7:0]                agen_sib,
  output logic [31:0]               agen_rel,
  output logic [15:0]               agen_ptr_cs,
  output logic [31:0]               agen_ptr_eip,
  output logic [3:0]                agen_pr_cnt,
  output logic                      agen_repne,
  output logic                      agen_opsize,
  output logic                      agen_seg_v,
  output logic [2:0]                agen_seg,
  output logic [31:0]               agen_next_eip,
  output logic [31:0]               inst_cnt
);
  import decode_pkg::*;

  logic [3:0]             w_pr_cnt;
  logic                   w_repne;
  logic                   w_opsize;
  logic                   w_seg_v;
  logic [2:0]             w_seg;
  logic                   w_overflow;
  logic [4:0]             w_len_sum;
  logic [FaultCauseW-1:0] w_cause;
  logic                   w_load;
  agen_res_t              w_res;

  logic                   r_v;
  agen_res_t              r_res;
  logic [31:0]            r_cnt;

  decode_prefix_scan #(
    .MAX_PREFIX   (MAX_PREFIX),
    .WINDOW_BYTES (WINDOW_BYTES)
  ) u_scan (
    .i_window   (de_window),
    .o_pr_cnt   (w_pr_cnt),
    .o_repne    (w_repne),
    .o_opsize   (w_opsize),
    .o_seg_v    (w_seg_v),
    .o_seg      (w_seg),
    .o_overflow (w_overflow)
  );

  // pr_cnt never exceeds MAX_PREFIX, so one constant-offset mux leg per legal count.
  always_comb begin
    w_res.opcode  = '0;
    w_res.modrm   = '0;
    w_res.sib     = '0;
    w_res.rel     = '0;
    w_res.ptr_cs  = '0;
    w_res.ptr_eip = '0;
    for (int p = 0; p <= int'(MAX_PREFIX); p++) begin
      if (w_pr_cnt == 4'(p)) begin
        w_res.opcode  = de_window[8*p +: 8];
        w_res.modrm   = de_window[8*(p+1) +: 8];
        w_res.sib     = de_window[8*(p+2) +: 8];
        w_res.rel     = de_window[8*(p+1) +: 32];
        w_res.ptr_cs  = de_window[8*(p+1) +: 16];
        w_res.ptr_eip = de_window[8*(p+3) +: 32];
      end
    end
  end

  assign w_len_sum = {1'b0, w_pr_cnt} + {1'b0, de_body_len};

  assign w_cause[FaultOverflow] = w_overflow;
  assign w_cause[FaultLenZero]  = (de_body_len == 4'd0);
  assign w_cause[FaultLenMax]   = (w_len_sum > 5'(MAX_INST_LEN));

  assign w_res.fault    = |w_cause;
  assign w_res.pr_cnt   = w_pr_cnt;
  assign w_res.repne    = w_repne;
  assign w_res.opsize   = w_opsize;
  assign w_res.seg_v    = w_seg_v;
  assign w_res.seg      = w_seg;
  assign w_res.next_eip = de_eip + 32'(w_len_sum);

  assign de_ready = !r_v || !agen_stall;
  assign w_load   = de_v && de_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v   <= 1'b0;
      r_res <= '0;
      r_cnt <= '0;
    end else begin
      if (flush) begin
        r_v <= 1'b0;
      end else if (w_load) begin
        r_v <= 1'b1;
      end else if (!agen_stall) begin
        r_v <= 1'b0;
      end
      if (w_load) begin
        r_res <= w_res;
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign agen_v        = r_v;
  assign agen_fault    = r_res.fault;
  assign agen_opcode   = r_res.opcode;
  assign agen_modrm    = r_res.modrm;
  assign agen_sib      = r_res.sib;
  assign agen_rel      = r_res.rel;
  assign agen_ptr_cs   = r_res.ptr_cs;
  assign agen_ptr_eip  = r_res.ptr_eip;
  assign agen_pr_cnt   = r_res.pr_cnt;
  assign agen_repne    = r_res.repne;
  assign agen_opsize   = r_res.opsize;
  assign agen_seg_v    = r_res.seg_v;
  assign agen_seg      = r_res.seg;
  assign agen_next_eip = r_res.next_eip;
  assign inst_cnt      = r_cnt;

endmodule
